moving_average_filter: RTL and testbench
========================================

Name: moving_average_filter

Overview:
- Parametrised N-tap moving-average (boxcar) filter for the audio datapath.
- Keeps a circular delay line of the last N accepted samples and a running sum. Each accepted sample adds the new value and subtracts the one being evicted.
- Output is the running sum divided by N, registered.
- Sits between the codec sample stream and downstream audio consumers, one instance per channel.

Parameters:
- DATA_W, 24, sample and output width (signed two's complement).
- LOG2_N, 3, log2 of tap count; N = 2**LOG2_N, legal range 1..8.

Ports:
- Clock  input  1  system clock, rising-edge.
- Reset_n  input  1  asynchronous active-low reset.
- enable  input  1  sample strobe; D is accepted on a rising edge with enable=1.
- clear  input  1  synchronous flush of filter state.
- D  input  DATA_W  signed input sample.
- Q  output  DATA_W  signed filtered sample, floor(sum/N) by default.
- out_valid  output  1  one-cycle pulse when Q has been updated.
- primed  output  1  high once N samples have been accepted since the last reset or clear.

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - Q=0, out_valid=0, primed=0.
  - Accumulator, write pointer, fill count and all N delay-line entries are cleared to 0.
- State:
  - mem[0..N-1], each DATA_W wide.
  - wr_ptr, LOG2_N bits.
  - acc, signed, DATA_W+LOG2_N bits, so it cannot overflow.
  - fill count, 0..N, saturating at N.
- Accept (enable=1, clear=0) on a rising edge:
  - acc_next = acc + sext(D) - sext(mem[wr_ptr]).
  - acc <= acc_next; mem[wr_ptr] <= D; wr_ptr <= wr_ptr+1, wrapping N-1 -> 0.
  - Q <= acc_next >>> LOG2_N (arithmetic shift, i.e. floor).
  - out_valid <= 1.
  - count <= min(count+1, N).
- Latency: Q reflects D on the edge that accepts it. Q is valid and out_valid is high during the following cycle.
- Idle (enable=0): all state and Q hold; out_valid <= 0.
- Warm-up: mem starts at zero, so the first N-1 outputs are partial averages (sum of the accepted samples / N). primed goes high on the edge that accepts the Nth sample and stays high until reset or clear.
- Clear:
  - clear=1 has priority over enable; the sample presented with it is discarded.
  - Zeroes acc, wr_ptr, count, every mem entry and Q; out_valid <= 0, primed <= 0.
- Arithmetic:
  - Because acc carries LOG2_N guard bits, acc >>> LOG2_N always fits DATA_W; no saturation logic is needed.
  - sext = sign extension to acc width.
- Reset asserted mid-stream: immediate return to the reset state. Operation resumes on the first enable after Reset_n deasserts.
- enable may be asserted on consecutive cycles: one sample per clock, no back-pressure.

Optional Feature:
- Macro: MAF_ROUND_EN.
- Defined: Q <= (acc_next + 2**(LOG2_N-1)) >>> LOG2_N, i.e. round half toward +infinity. The rounding add is done at acc width + 1 bit. Results above 2**(DATA_W-1)-1 are clamped to that value.
- Undefined: plain arithmetic-shift truncation (floor), with no rounding adder.

Test Plan (DATA_W=24, LOG2_N=3):
- Reset, then eight consecutive enables with D=800:
  - Q = 100, 200, ..., 800 on successive cycles; out_valid high each cycle.
  - primed rises with the 8th sample.
  - Then eight enables with D=0: Q = 700, 600, ..., 0.
- Eight enables with D=8388607 (max positive): Q=8388607, no wrap. Then eight with D=-8388608: Q settles at -8388608.
- From reset, single enable with D=-8: Q=-1 (floor). With MAF_ROUND_EN: D=4 gives Q=1, and D=-4 gives Q=0; without it the same stimuli give Q=0 and Q=-1.
- Gaps in the stream: feed 10,20,30 with enable low for 3 cycles between samples:
  - Q holds between samples; out_valid pulses only after each accept.
  - Q sequence 1, 3, 7 (floor of 10/8, 30/8, 60/8).
- Prime with D=800 ×8, then assert clear together with enable and D=5000:
  - Next cycle Q=0, primed=0, out_valid=0.
  - A following accept of D=80 gives Q=10, so no stale history remains.
- Prime with D=800 ×8, then pull Reset_n low between clock edges:
  - Q=0, primed=0 immediately, with no clock edge needed.
  - After release, D=160 gives Q=20.

Source files
------------

// File: rtl/moving_average_filter_if.sv
// Sample-stream bundle between the codec/consumer side and one moving_average_filter.
// The master drives samples and control; the slave returns the filtered sample and status.
interface moving_average_filter_if #(
    parameter int DATA_W = 24
);
    logic                     enable;
    logic                     clear;
    logic signed [DATA_W-1:0] D;
    logic signed [DATA_W-1:0] Q;
    logic                     out_valid;
    logic                     primed;

    modport master (
        output enable,
        output clear,
        output D,
        input  Q,
        input  out_valid,
        input  primed
    );

    modport slave (
        input  enable,
        input  clear,
        input  D,
        output Q,
        output out_valid,
        output primed
    );
endinterface

// File: rtl/moving_average_filter.sv
// N-tap boxcar filter: circular delay line plus running sum, output = sum / N (registered).
// Optional macro MAF_ROUND_EN selects round-half-up with positive clamp instead of floor.
module moving_average_filter #(
    parameter int DATA_W = 24,
    parameter int LOG2_N = 3
) (
    input  logic                   Clock,
    input  logic                   Reset_n,
    moving_average_filter_if.slave bus
);
    localparam int N     = 1 << LOG2_N;
    localparam int ACC_W = DATA_W + LOG2_N;
    localparam logic [LOG2_N:0] N_CNT = (LOG2_N + 1)'(N);

    logic signed [DATA_W-1:0] mem_q [N];
    logic signed [DATA_W-1:0] mem_d [N];
    logic [LOG2_N-1:0]        wr_ptr_q, wr_ptr_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d, acc_next;
    logic [LOG2_N:0]          count_q, count_d;
    logic signed [DATA_W-1:0] q_q, q_d;
    logic                     out_valid_q, out_valid_d;
    logic                     primed_q, primed_d;

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [DATA_W-1:0] x);
        return {{LOG2_N{x[DATA_W-1]}}, x};
    endfunction

`ifdef MAF_ROUND_EN
    localparam logic [ACC_W:0] HALF = (ACC_W + 1)'(1) << (LOG2_N - 1);

    // Round half toward +inf; only the positive side can exceed DATA_W after the add.
    function automatic logic signed [DATA_W-1:0] scale(input logic signed [ACC_W-1:0] a);
        logic [ACC_W:0]  r;
        logic [DATA_W:0] s;
        r = {a[ACC_W-1], a} + HALF;
        s = r[ACC_W:LOG2_N];
        if (!s[DATA_W] && s[DATA_W-1])
            return {1'b0, {(DATA_W-1){1'b1}}};
        return s[DATA_W-1:0];
    endfunction
`else
    function automatic logic signed [DATA_W-1:0] scale(input logic signed [ACC_W-1:0] a);
        return a[ACC_W-1:LOG2_N];
    endfunction
`endif

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        acc_d       = acc_q;
        count_d     = count_q;
        q_d         = q_q;
        out_valid_d = 1'b0;
        acc_next    = acc_q + sext(bus.D) - sext(mem_q[wr_ptr_q]);

        if (bus.clear) begin
            for (int i = 0; i < N; i++) mem_d[i] = '0;
            wr_ptr_d = '0;
            acc_d    = '0;
            count_d  = '0;
            q_d      = '0;
        end else if (bus.enable) begin
            mem_d[wr_ptr_q] = bus.D;
            wr_ptr_d        = wr_ptr_q + 1'b1;
            acc_d           = acc_next;
            q_d             = scale(acc_next);
            out_valid_d     = 1'b1;
            if (count_q != N_CNT) count_d = count_q + 1'b1;
        end

        primed_d = (count_d == N_CNT);
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < N; i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            acc_q       <= '0;
            count_q     <= '0;
            q_q         <= '0;
            out_valid_q <= 1'b0;
            primed_q    <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            q_q         <= q_d;
            out_valid_q <= out_valid_d;
            primed_q    <= primed_d;
        end
    end

    assign bus.Q         = q_q;
    assign bus.out_valid = out_valid_q;
    assign bus.primed    = primed_q;
endmodule

// File: tb/tb_moving_average_filter.sv
// Directed bench for moving_average_filter with a sliding-window reference model and
// an expected-output queue; rounding expectations follow MAF_ROUND_EN when defined.
module tb_moving_average_filter;
    localparam int DATA_W = 24;
    localparam int LOG2_N = 3;
    localparam int N      = 1 << LOG2_N;
    localparam longint MAXV = (64'sd1 <<< (DATA_W - 1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (DATA_W - 1));

    logic Clock = 1'b0;
    logic Reset_n;

    moving_average_filter_if #(.DATA_W(DATA_W)) bus ();

    moving_average_filter #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) dut (
        .Clock  (Clock),
        .Reset_n(Reset_n),
        .bus    (bus)
    );

    always #5 Clock = ~Clock;

    int     checks   = 0;
    int     failures = 0;
    longint hist[$];
    longint exp_q[$];
    longint last_q = 0;

    function automatic longint model_q(input longint s);
        longint r;
`ifdef MAF_ROUND_EN
        r = (s + N / 2) >>> LOG2_N;
        if (r > MAXV) r = MAXV;
`else
        r = s >>> LOG2_N;
`endif
        return r;
    endfunction

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic en, input logic clr, input longint d);
        longint sum;
        logic signed [63:0] dv;
        dv = d;
        @(negedge Clock);
        bus.enable = en;
        bus.clear  = clr;
        bus.D      = dv[DATA_W-1:0];
        if (clr) begin
            hist.delete();
            last_q = 0;
        end else if (en) begin
            hist.push_back(d);
            if (hist.size() > N) void'(hist.pop_front());
            sum = 0;
            foreach (hist[i]) sum += hist[i];
            exp_q.push_back(model_q(sum));
        end
        @(posedge Clock);
        #1;
        if (en && !clr) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 1, 0);
            end else begin
                last_q = exp_q.pop_front();
                check("q", bus.Q, last_q);
            end
            check("out_valid_accept", bus.out_valid, 1);
        end else begin
            check("q_hold", bus.Q, last_q);
            check("out_valid_idle", bus.out_valid, 0);
        end
        check("primed", bus.primed, (hist.size() == N) ? 1 : 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0);
    endtask

    // Reset is dropped between edges and checked before any further clock edge.
    task automatic async_reset();
        @(negedge Clock);
        bus.enable = 1'b0;
        bus.clear  = 1'b0;
        #2;
        Reset_n = 1'b0;
        #1;
        check("rst_q", bus.Q, 0);
        check("rst_primed", bus.primed, 0);
        check("rst_out_valid", bus.out_valid, 0);
        hist.delete();
        exp_q.delete();
        last_q = 0;
        @(negedge Clock);
        Reset_n = 1'b1;
    endtask

    initial begin
        Reset_n    = 1'b0;
        bus.enable = 1'b0;
        bus.clear  = 1'b0;
        bus.D      = '0;
        repeat (2) @(posedge Clock);
        #1;
        check("reset_q", bus.Q, 0);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_primed", bus.primed, 0);
        @(negedge Clock);
        Reset_n = 1'b1;

        // Ramp up and down with a constant 800.
        for (int i = 1; i <= N; i++) begin
            step(1'b1, 1'b0, 800);
            check("plan_ramp_up", bus.Q, 100 * i);
        end
        for (int i = 1; i <= N; i++) begin
            step(1'b1, 1'b0, 0);
            check("plan_ramp_down", bus.Q, 800 - 100 * i);
        end

        // Full-scale extremes must not wrap.
        for (int i = 0; i < N; i++) step(1'b1, 1'b0, MAXV);
        check("plan_max", bus.Q, MAXV);
        for (int i = 0; i < N; i++) step(1'b1, 1'b0, MINV);
        check("plan_min", bus.Q, MINV);

        // Floor versus rounding on small values.
        async_reset();
        step(1'b1, 1'b0, -8);
        check("plan_neg8", bus.Q, -1);
        async_reset();
        step(1'b1, 1'b0, 4);
`ifdef MAF_ROUND_EN
        check("plan_pos4", bus.Q, 1);
`else
        check("plan_pos4", bus.Q, 0);
`endif
        async_reset();
        step(1'b1, 1'b0, -4);
`ifdef MAF_ROUND_EN
        check("plan_neg4", bus.Q, 0);
`else
        check("plan_neg4", bus.Q, -1);
`endif

        // Gapped stream: Q holds and out_valid only pulses after accepts.
        async_reset();
        step(1'b1, 1'b0, 10);
        idle(3);
        step(1'b1, 1'b0, 20);
        idle(3);
        step(1'b1, 1'b0, 30);
`ifndef MAF_ROUND_EN
        check("plan_gap_last", bus.Q, 7);
`endif
        idle(2);

        // Clear wins over enable and removes all history.
        for (int i = 0; i < N; i++) step(1'b1, 1'b0, 800);
        step(1'b1, 1'b1, 5000);
        check("plan_clear_q", bus.Q, 0);
        check("plan_clear_primed", bus.primed, 0);
        step(1'b1, 1'b0, 80);
        check("plan_after_clear", bus.Q, 10);

        // Asynchronous reset mid-stream, then resume.
        for (int i = 0; i < N; i++) step(1'b1, 1'b0, 800);
        async_reset();
        step(1'b1, 1'b0, 160);
        check("plan_after_reset", bus.Q, 20);

        // Back-to-back random samples against the sliding-window model.
        for (int i = 0; i < 40; i++)
            step(1'b1, 1'b0, longint'($signed($urandom_range(0, 2000))) - 1000);
        idle(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
